// File: rtl/floatingpointpkg.sv
// Shared floating-point types and the arbiter FSM state encoding.
// Latency: n/a (types only).
// Backpressure: n/a.
package floatingpointpkg;

    typedef logic [31:0] float;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/fp_rr_picker.sv
// Round-robin picker: first set request at or after ptr, wrapping to 0.
// Latency: combinational.
// Backpressure: none; the caller decides when the pick is consumed.
module fp_rr_picker #(
    parameter int NREQ = 4,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic            gnt_vld,
    output logic [PW-1:0]   gnt_idx
);

    logic [2*NREQ-1:0] req_rot_wide;
    logic [NREQ-1:0]   req_rot;
    logic [PW:0]       idx_sum;
    logic [PW-1:0]     offset;

    assign req_rot_wide = {req, req} >> ptr;
    assign req_rot      = req_rot_wide[NREQ-1:0];

    // Lowest set bit of the rotated vector is the nearest requester after ptr.
    always_comb begin
        gnt_vld = 1'b0;
        offset  = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                gnt_vld = 1'b1;
                offset  = i[PW-1:0];
            end
        end
    end

    always_comb begin
        idx_sum = {1'b0, ptr} + {1'b0, offset};
        if (idx_sum >= (PW+1)'(NREQ)) begin
            idx_sum = idx_sum - (PW+1)'(NREQ);
        end
        gnt_idx = idx_sum[PW-1:0];
    end

endmodule

// File: rtl/fp_add_arbiter.sv
// Shares one floating-point adder among NREQ requesters, round-robin, with a WAIT timeout.
// Latency: req in IDLE at t -> ack/add_go at t+1 -> done at t+3+k (k = WAIT cycles before add_ready).
// Backpressure: requests are sampled only in IDLE; unserved requesters must hold req.
module fp_add_arbiter
    import floatingpointpkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  float            opa [NREQ],
    input  float            opb [NREQ],
    output logic [NREQ-1:0] ack,
    output logic [NREQ-1:0] done,
    output float            rsp_result,
    output logic            rsp_zero,
    output logic            rsp_inf,
    output logic            rsp_nan,
    output logic            rsp_timeout,
    output logic            busy,
    output float            add_a,
    output float            add_b,
    output logic            add_go,
    input  float            add_result,
    input  logic            add_ready,
    input  logic            add_zero,
    input  logic            add_inf,
    input  logic            add_nan
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    arb_state_t    state_q;
    arb_state_t    state_d;
    logic [PW-1:0] ptr_q;
    logic [PW-1:0] gidx_q;
    logic [TW-1:0] timer_q;
    logic          pick_vld;
    logic [PW-1:0] pick_idx;
    logic          timed_out;

    fp_rr_picker #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_picker (
        .req     (req),
        .ptr     (ptr_q),
        .gnt_vld (pick_vld),
        .gnt_idx (pick_idx)
    );

    // Timer is zero on the first WAIT cycle, so TLAST marks the TIMEOUT-th one.
    assign timed_out = (timer_q == TLAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_vld) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (add_ready || timed_out) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ack    = '0;
        done   = '0;
        add_go = 1'b0;
        busy   = (state_q != IDLE);
        case (state_q)
            ISSUE: begin
                add_go      = 1'b1;
                ack[gidx_q] = 1'b1;
            end
            RESP:    done[gidx_q] = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= '0;
            gidx_q      <= '0;
            timer_q     <= '0;
            add_a       <= '0;
            add_b       <= '0;
            rsp_result  <= '0;
            rsp_zero    <= 1'b0;
            rsp_inf     <= 1'b0;
            rsp_nan     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_vld) begin
                        gidx_q <= pick_idx;
                        add_a  <= opa[pick_idx];
                        add_b  <= opb[pick_idx];
                        ptr_q  <= (pick_idx == PW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
                    end
                end
                ISSUE: timer_q <= '0;
                WAIT: begin
                    timer_q <= timer_q + 1'b1;
                    // Ready wins over a coincident timeout.
                    if (add_ready) begin
                        rsp_result  <= add_result;
                        rsp_zero    <= add_zero;
                        rsp_inf     <= add_inf;
                        rsp_nan     <= add_nan;
                        rsp_timeout <= 1'b0;
                    end else if (timed_out) begin
                        rsp_result  <= '0;
                        rsp_zero    <= 1'b0;
                        rsp_inf     <= 1'b0;
                        rsp_nan     <= 1'b0;
                        rsp_timeout <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Bench for fp_add_arbiter: behavioural adder with selectable latency/stuck modes and a round-robin reference model.
module tb_fp_add_arbiter;
    import floatingpointpkg::*;

    localparam int NREQ    = 4;
    localparam int TIMEOUT = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic [NREQ-1:0] req;
    float            opa [NREQ];
    float            opb [NREQ];
    logic [NREQ-1:0] ack, done;
    float            rsp_result, add_a, add_b, add_result;
    logic            rsp_zero, rsp_inf, rsp_nan, rsp_timeout, busy, add_go;
    logic            add_ready, add_zero, add_inf, add_nan;

    int errors = 0;
    int checks = 0;
    int ptr_m  = 0;
    int amode  = 0;   // 0: latency alat, 1: never ready, 2: ready stuck high
    int alat   = 1;

    always #5 clk = ~clk;

    fp_add_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .req(req), .opa(opa), .opb(opb),
        .ack(ack), .done(done), .rsp_result(rsp_result), .rsp_zero(rsp_zero),
        .rsp_inf(rsp_inf), .rsp_nan(rsp_nan), .rsp_timeout(rsp_timeout), .busy(busy),
        .add_a(add_a), .add_b(add_b), .add_go(add_go), .add_result(add_result),
        .add_ready(add_ready), .add_zero(add_zero), .add_inf(add_inf), .add_nan(add_nan)
    );

    function automatic real f2r(logic [31:0] f);
        real v;
        int  e;
        if (f[30:23] == 8'h00) return 0.0;
        v = 1.0 + real'(f[22:0]) / 8388608.0;
        e = int'(f[30:23]) - 127;
        while (e > 0) begin v = v * 2.0; e--; end
        while (e < 0) begin v = v / 2.0; e++; end
        return f[31] ? -v : v;
    endfunction

    function automatic logic [31:0] r2f(real r);
        logic [63:0] d;
        int          e;
        if (r == 0.0) return 32'h0;
        d = $realtobits(r);
        e = int'(d[62:52]) - 1023 + 127;
        if (e <= 0) return {d[63], 31'h0};
        return {d[63], e[7:0], d[51:29]};
    endfunction

    // Returns {sum, zero, inf, nan}.
    function automatic logic [34:0] fadd(logic [31:0] a, logic [31:0] b);
        logic [31:0] r;
        logic        a_sp, b_sp;
        a_sp = (a[30:23] == 8'hFF);
        b_sp = (b[30:23] == 8'hFF);
        if (a_sp || b_sp) begin
            if ((a_sp && a[22:0] != 0) || (b_sp && b[22:0] != 0) || (a_sp && b_sp && a[31] != b[31]))
                return {32'h7FC00000, 3'b001};
            r = a_sp ? a : b;
            return {r, 3'b010};
        end
        r = r2f(f2r(a) + f2r(b));
        return {r, (r[30:0] == 31'h0), 2'b00};
    endfunction

    function automatic logic [31:0] rnd_f();
        return {1'($urandom_range(0, 1)), 8'($urandom_range(110, 140)), 23'($urandom)};
    endfunction

    function automatic int model_pick(logic [NREQ-1:0] r, int p);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    // Behavioural adder: result appears alat cycles into WAIT (k = alat).
    logic        rdy_q = 1'b0;
    logic        apend = 1'b0;
    int          acnt  = 0;
    logic [34:0] aq_out = '0, aq_pend = '0, stuck_out;

    always @(posedge clk) begin
        rdy_q <= 1'b0;
        if (add_go) begin
            if (alat == 0) begin
                rdy_q  <= 1'b1;
                aq_out <= fadd(add_a, add_b);
                apend  <= 1'b0;
            end else begin
                aq_pend <= fadd(add_a, add_b);
                acnt    <= alat - 1;
                apend   <= 1'b1;
            end
        end else if (apend) begin
            if (acnt == 0) begin
                rdy_q  <= 1'b1;
                aq_out <= aq_pend;
                apend  <= 1'b0;
            end else begin
                acnt <= acnt - 1;
            end
        end
    end

    assign stuck_out = fadd(add_a, add_b);
    assign add_ready = (amode == 2) ? 1'b1 : (amode == 1) ? 1'b0 : rdy_q;
    assign {add_result, add_zero, add_inf, add_nan} = (amode == 2) ? stuck_out : aq_out;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives req from an IDLE cycle, follows one transaction, and returns in the following IDLE cycle.
    task automatic run_txn(input logic [NREQ-1:0] r, input bit drop,
                           output int ack_lat, output logic [NREQ-1:0] ack_v, output logic go_v,
                           output int done_lat, output logic [NREQ-1:0] done_v, output logic busy_after);
        ack_lat = -1; ack_v = '0; go_v = 1'b0;
        done_lat = -1; done_v = '0; busy_after = 1'b1;
        req = r;
        for (int i = 1; i <= 4; i++) begin
            tick();
            if (ack != 0) begin ack_lat = i; ack_v = ack; go_v = add_go; break; end
        end
        if (ack_lat < 0) return;
        if (drop) req = '0;
        for (int i = 1; i <= TIMEOUT + 8; i++) begin
            tick();
            if (done != 0) begin done_lat = i; done_v = done; break; end
        end
        if (done_lat < 0) return;
        tick();
        busy_after = busy;
    endtask

    int              al, dl;
    logic [NREQ-1:0] av, dv, eoh;
    logic            gv, ba;
    logic [34:0]     exp_rsp;
    int              eg;

    task automatic test_reset();
        rst = 1'b1; req = '0; amode = 0; alat = 1;
        for (int i = 0; i < NREQ; i++) begin opa[i] = rnd_f(); opb[i] = rnd_f(); end
        tick(); tick();
        checks++;
        if ({busy, add_go, ack, done} !== '0) begin
            errors++; $display("FAIL reset_ctrl actual=%b required=0", {busy, add_go, ack, done});
        end
        checks++;
        if ({add_a, add_b} !== 64'h0) begin
            errors++; $display("FAIL reset_operands actual=%h required=0", {add_a, add_b});
        end
        checks++;
        if ({rsp_result, rsp_zero, rsp_inf, rsp_nan, rsp_timeout} !== 36'h0) begin
            errors++; $display("FAIL reset_rsp actual=%h required=0", {rsp_result, rsp_zero, rsp_inf, rsp_nan, rsp_timeout});
        end
        rst = 1'b0; ptr_m = 0;
        tick();
    endtask

    task automatic test_basic_add();
        req = '0; amode = 0; alat = 2;
        opa[2] = 32'h3FC00000; opb[2] = 32'h40100000;
        run_txn(4'b0100, 1'b1, al, av, gv, dl, dv, ba);
        ptr_m = 3;
        checks++;
        if (al !== 1 || av !== 4'b0100 || gv !== 1'b1) begin
            errors++; $display("FAIL basic_ack actual=lat%0d ack=%b go=%b required=lat1 ack=0100 go=1", al, av, gv);
        end
        checks++;
        if (dl !== 4 || dv !== 4'b0100) begin
            errors++; $display("FAIL basic_done actual=+%0d %b required=+4 0100", dl, dv);
        end
        checks++;
        if ({rsp_result, rsp_zero, rsp_inf, rsp_nan, rsp_timeout} !== {32'h40700000, 4'b0000}) begin
            errors++; $display("FAIL basic_sum actual=%h flags=%b required=40700000 flags=0000", rsp_result, {rsp_zero, rsp_inf, rsp_nan, rsp_timeout});
        end
        checks++;
        if (ba !== 1'b0) begin errors++; $display("FAIL basic_busy_after actual=%b required=0", ba); end
    endtask

    task automatic rr_step(input logic [NREQ-1:0] r, input string tag);
        alat = $urandom_range(0, 3);
        for (int i = 0; i < NREQ; i++) begin opa[i] = rnd_f(); opb[i] = rnd_f(); end
        eg = model_pick(r, ptr_m);
        eoh = '0; eoh[eg] = 1'b1;
        exp_rsp = fadd(opa[eg], opb[eg]);
        run_txn(r, 1'b0, al, av, gv, dl, dv, ba);
        ptr_m = (eg + 1) % NREQ;
        checks++;
        if (av !== eoh || dv !== eoh) begin
            errors++; $display("FAIL %s_grant actual=ack%b done%b required=%b", tag, av, dv, eoh);
        end
        checks++;
        if (dl !== 2 + alat) begin errors++; $display("FAIL %s_latency actual=%0d required=%0d", tag, dl, 2 + alat); end
        checks++;
        if ({rsp_result, rsp_zero, rsp_inf, rsp_nan, rsp_timeout} !== {exp_rsp, 1'b0}) begin
            errors++; $display("FAIL %s_rsp actual=%h required=%h", tag, {rsp_result, rsp_zero, rsp_inf, rsp_nan, rsp_timeout}, {exp_rsp, 1'b0});
        end
    endtask

    task automatic test_round_robin();
        rst = 1'b1; req = 4'b1111; amode = 0;
        tick();
        rst = 1'b0; ptr_m = 0;
        for (int n = 0; n < 5; n++) rr_step(4'b1111, "rr_all");
        for (int n = 0; n < 4; n++) rr_step(4'b1001, "rr_pair");
        req = '0;
    endtask

    task automatic test_random();
        amode = 0;
        for (int n = 0; n < 20; n++) begin
            req = '0;
            if ($urandom_range(0, 3) == 0) begin
                tick(); tick();
                checks++;
                if (ack !== '0 || busy !== 1'b0) begin
                    errors++; $display("FAIL idle_noreq actual=ack%b busy%b required=0", ack, busy);
                end
            end
            rr_step(4'($urandom_range(1, 15)), "rand");
        end
        req = '0;
    endtask

    task automatic test_timeout();
        req = '0; amode = 1;
        run_txn(4'b0010, 1'b1, al, av, gv, dl, dv, ba);
        eg = model_pick(4'b0010, ptr_m); ptr_m = (eg + 1) % NREQ;
        checks++;
        if (dl !== TIMEOUT + 1 || dv !== 4'b0010) begin
            errors++; $display("FAIL timeout_done actual=+%0d %b required=+%0d 0010", dl, dv, TIMEOUT + 1);
        end
        checks++;
        if ({rsp_result, rsp_zero, rsp_inf, rsp_nan, rsp_timeout} !== {32'h0, 4'b0001}) begin
            errors++; $display("FAIL timeout_rsp actual=%h flags=%b required=0 flags=0001", rsp_result, {rsp_zero, rsp_inf, rsp_nan, rsp_timeout});
        end
        checks++;
        if (ba !== 1'b0) begin errors++; $display("FAIL timeout_busy_after actual=%b required=0", ba); end
        amode = 0;
    endtask

    task automatic test_stuck_ready();
        req = '0; amode = 2;
        opa[3] = rnd_f(); opb[3] = rnd_f();
        exp_rsp = fadd(opa[3], opb[3]);
        run_txn(4'b1000, 1'b1, al, av, gv, dl, dv, ba);
        eg = model_pick(4'b1000, ptr_m); ptr_m = (eg + 1) % NREQ;
        checks++;
        if (al !== 1 || dl !== 2 || dv !== 4'b1000) begin
            errors++; $display("FAIL stuck_latency actual=ack+%0d done+%0d %b required=ack+1 done+2 1000", al, dl, dv);
        end
        checks++;
        if ({rsp_result, rsp_zero, rsp_inf, rsp_nan, rsp_timeout} !== {exp_rsp, 1'b0}) begin
            errors++; $display("FAIL stuck_rsp actual=%h required=%h", {rsp_result, rsp_zero, rsp_inf, rsp_nan, rsp_timeout}, {exp_rsp, 1'b0});
        end
        amode = 0;
    endtask

    task automatic test_inf_nan();
        req = '0; amode = 0; alat = 1;
        opa[0] = 32'h7F800000; opb[0] = 32'hFF800000;
        run_txn(4'b0001, 1'b1, al, av, gv, dl, dv, ba);
        eg = model_pick(4'b0001, ptr_m); ptr_m = (eg + 1) % NREQ;
        checks++;
        if (dv !== 4'b0001 || {rsp_zero, rsp_inf, rsp_nan, rsp_timeout} !== 4'b0010) begin
            errors++; $display("FAIL inf_nan actual=done%b flags=%b required=done0001 flags=0010", dv, {rsp_zero, rsp_inf, rsp_nan, rsp_timeout});
        end
    endtask

    task automatic test_drop_before_grant();
        int seen;
        req = '0; amode = 0; alat = 4;
        req = 4'b0001;
        tick();
        req = 4'b0010;
        tick();
        req = '0;
        seen = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (ack[1]) seen++;
        end
        ptr_m = 1;
        checks++;
        if (seen !== 0 || busy !== 1'b0) begin
            errors++; $display("FAIL drop_before_grant actual=acks%0d busy%b required=0 0", seen, busy);
        end
    endtask

    task automatic test_reset_mid();
        int seen_done, seen_busy;
        req = '0; amode = 0; alat = 10;
        opa[2] = rnd_f(); opb[2] = rnd_f();
        req = 4'b0100;
        tick();
        req = '0;
        tick(); tick();
        rst = 1'b1;
        tick();
        checks++;
        if ({busy, add_go, ack, done} !== '0 || {add_a, add_b} !== 64'h0) begin
            errors++; $display("FAIL reset_mid_state actual=ctrl%b a=%h b=%h required=0", {busy, add_go, ack, done}, add_a, add_b);
        end
        rst = 1'b0; ptr_m = 0;
        seen_done = 0; seen_busy = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (done != 0) seen_done++;
            if (busy) seen_busy++;
        end
        checks++;
        if (seen_done !== 0 || seen_busy !== 0) begin
            errors++; $display("FAIL reset_mid_late_ready actual=done%0d busy%0d required=0 0", seen_done, seen_busy);
        end
        alat = 1;
        run_txn(4'b1111, 1'b1, al, av, gv, dl, dv, ba);
        checks++;
        if (av !== 4'b0001) begin errors++; $display("FAIL reset_mid_ptr actual=%b required=0001", av); end
        ptr_m = 1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic_add();
        test_round_robin();
        test_random();
        test_timeout();
        test_stuck_ready();
        test_inf_nan();
        test_drop_before_grant();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
